// File: rtl/tx_deficit_scheduler.sv
// Deficit round-robin arbiter for the ICMP/UDP/TCP transmit requesters.
// Define TX_SCHED_PERF_EN to add per-port grant and abort counters.
module tx_deficit_scheduler #(
   parameter int unsigned QUANTUM     = 1536,
   parameter int unsigned MAX_DEFICIT = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       req,
   input  logic [2:0][15:0] req_len,
   input  logic             frame_done,
   input  logic             tx_busy,
   output logic [2:0]       grant,
`ifdef TX_SCHED_PERF_EN
   output logic [2:0][31:0] perf_frames,
   output logic [31:0]      perf_aborts,
`endif
   output logic             sched_busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_EVAL    = 2'd1;
   localparam logic [1:0] S_GRANTED = 2'd2;

   localparam logic [17:0] LP_Q   = 18'(QUANTUM);
   localparam logic [17:0] LP_MAX = 18'(MAX_DEFICIT);

   logic [1:0]       r_state;
   logic [1:0]       r_ptr;
   logic [2:0][16:0] r_deficit;
   logic [2:0]       r_grant;

   logic        w_req_cur;
   logic [15:0] w_len_cur;
   logic [16:0] w_def_cur;
   logic [17:0] w_sum;
   logic [16:0] w_credit;
   logic        w_fit;
   logic [1:0]  w_ptr_nxt;
   logic [2:0]  w_onehot;
   logic        w_def_we;
   logic [16:0] w_def_nxt;
   logic        w_grant_evt;
   logic        w_abort_evt;

   always_comb begin
      w_req_cur = 1'b0;
      w_len_cur = '0;
      w_def_cur = '0;
      w_onehot  = 3'b000;
      unique case (r_ptr)
         2'd0: begin
            w_req_cur = req[0];
            w_len_cur = req_len[0];
            w_def_cur = r_deficit[0];
            w_onehot  = 3'b001;
         end
         2'd1: begin
            w_req_cur = req[1];
            w_len_cur = req_len[1];
            w_def_cur = r_deficit[1];
            w_onehot  = 3'b010;
         end
         2'd2: begin
            w_req_cur = req[2];
            w_len_cur = req_len[2];
            w_def_cur = r_deficit[2];
            w_onehot  = 3'b100;
         end
         default: ;
      endcase
   end

   // 18-bit sum so the credit saturates instead of wrapping
   assign w_sum     = {1'b0, w_def_cur} + LP_Q;
   assign w_credit  = (w_sum > LP_MAX) ? LP_MAX[16:0] : w_sum[16:0];
   assign w_fit     = w_def_cur >= {1'b0, w_len_cur};
   assign w_ptr_nxt = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;

   assign w_grant_evt = (r_state == S_EVAL) && w_req_cur && w_fit;
   assign w_abort_evt = (r_state == S_GRANTED) && !frame_done && !w_req_cur;

   always_comb begin
      w_def_we  = 1'b0;
      w_def_nxt = '0;
      if (r_state == S_EVAL) begin
         w_def_we = 1'b1;
         if (!w_req_cur)
            w_def_nxt = '0;
         else if (w_fit)
            w_def_nxt = w_def_cur - {1'b0, w_len_cur};
         else
            w_def_nxt = w_credit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_deficit <= '0;
         r_grant   <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++)
            if (w_def_we && r_ptr == 2'(i))
               r_deficit[i] <= w_def_nxt;
         unique case (r_state)
            S_IDLE: begin
               if (req != 3'b000 && !tx_busy)
                  r_state <= S_EVAL;
            end
            S_EVAL: begin
               if (!w_req_cur) begin
                  r_ptr <= w_ptr_nxt;
                  if (req == 3'b000)
                     r_state <= S_IDLE;
               end else if (w_fit) begin
                  r_grant <= w_onehot;
                  r_state <= S_GRANTED;
               end else begin
                  r_ptr <= w_ptr_nxt;
               end
            end
            S_GRANTED: begin
               // ptr is kept so leftover credit is spent on the same port
               if (frame_done || !w_req_cur) begin
                  r_grant <= 3'b000;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_grant <= 3'b000;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant      = r_grant;
   assign sched_busy = (r_state != S_IDLE);

`ifdef TX_SCHED_PERF_EN
   logic [2:0][31:0] r_perf_frames;
   logic [31:0]      r_perf_aborts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_frames <= '0;
         r_perf_aborts <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            if (w_grant_evt && r_ptr == 2'(i))
               r_perf_frames[i] <= r_perf_frames[i] + 32'd1;
         if (w_abort_evt)
            r_perf_aborts <= r_perf_aborts + 32'd1;
      end
   end

   assign perf_frames = r_perf_frames;
   assign perf_aborts = r_perf_aborts;
`endif

endmodule
